mem_copy_engine: RTL and testbench
==================================

Name: mem_copy_engine

Overview:
Initiator-side sequencer for the single-port word data memory interface: a combinational read path, and a write on the rising clock edge when writeEnable is high.
On a start request it copies a block of words from a source word address to a destination word address, one word at a time (read cycle, then write cycle).
It sits between a control master (test harness or future CPU/DMA control) and the data memory, which it drives directly.
It also produces a running XOR checksum of the transferred words for self-checking.

Parameters:
ADDR_WIDTH, 32, width of the word addresses; matches the memory address port (the memory decodes only the low 10 bits).
DATA_WIDTH, 32, memory word width.
LEN_WIDTH, 11, width of the length field; supports 0..1024 words.

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  copy request; sampled only in IDLE
srcAddr  input  ADDR_WIDTH  first source word address
dstAddr  input  ADDR_WIDTH  first destination word address
length  input  LEN_WIDTH  number of words to copy
busy  output  1  high in READ and WRITE states
done  output  1  one-cycle pulse when a copy completes (including length 0)
checksum  output  DATA_WIDTH  XOR of all words written by the current/last copy
memAddress  output  ADDR_WIDTH  to memory address
memWriteEnable  output  1  to memory writeEnable
memDataIn  output  DATA_WIDTH  to memory dataIn
memDataOut  input  DATA_WIDTH  from memory dataOut (combinational read)

Behaviour:
- One clock (clk). Reset is asynchronous and active-high.
- While reset is high, all of the following apply immediately (not at the next edge):
  - state = IDLE
  - busy = 0, done = 0, checksum = 0
  - memAddress = 0, memWriteEnable = 0, memDataIn = 0
  - internal counters and the hold register = 0
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - Outputs: memWriteEnable = 0, memAddress = 0.
  - On an edge with start = 1: latch srcAddr, dstAddr and length; clear checksum.
  - Next state is READ if length != 0, else DONE.
- READ:
  - Outputs: memAddress = current src, memWriteEnable = 0.
  - At the edge: hold <= memDataOut; next state WRITE.
- WRITE:
  - Outputs: memAddress = current dst, memWriteEnable = 1, memDataIn = hold.
  - At the edge: checksum <= checksum ^ hold; src += 1; dst += 1; remaining -= 1.
  - Next state is DONE if remaining was 1, else READ.
- DONE:
  - Outputs: done = 1 for exactly this cycle; busy = 0; memWriteEnable = 0.
  - Next state is IDLE unconditionally.
  - start is ignored in DONE.
- start asserted while busy or in DONE is ignored; no queuing.
- Latency: an N-word copy spends 2N cycles busy, then 1 done cycle. A zero-length copy gives done one cycle after start is accepted, with no writes.
- Address arithmetic: src/dst increment modulo 2^ADDR_WIDTH. The memory aliases on the low 10 bits, so a wrap past 1023 lands on word 0; this is legal and not flagged.
- Overlap: the copy is strictly forward and word-sequential (each word is read, then written, before the next read).
  - With dst = src+k, k < length, earlier written words are re-read; the result is the defined forward-propagation pattern.
  - src = dst rewrites identical data.
- checksum holds its value after DONE until the next accepted start or reset.
- Reset mid-copy: the abort is immediate, memWriteEnable drops asynchronously, and words already written stay written. No done pulse is produced.
- memDataIn is a registered value (hold) and is only meaningful while memWriteEnable = 1.

Test Plan:
1. Preload mem[0..3] = 11111111, 22222222, 33333333, 44444444. Start with src=0, dst=16, len=4 -> mem[16..19] match mem[0..3]; busy high for exactly 8 cycles; done pulses on cycle 9; checksum = 44444444.
2. len=0, src=5, dst=9 -> done one cycle after start; memWriteEnable never asserted; checksum = 0; mem[9] unchanged.
3. Overlap forward copy with mem[0]=DEADBEEF, src=0, dst=1, len=4 -> mem[1..4] all DEADBEEF; checksum = 0.
4. Wrap-around: src=1022, dst=100, len=4 with mem[1022]=A, mem[1023]=B, mem[0]=C, mem[1]=D -> mem[100..103] = A, B, C, D.
5. Start pulsed again during busy, with different addresses -> the second request is ignored. After done, a new start is accepted and clears checksum before accumulating.
6. Reset asserted between edges mid-copy (len=8, after 3 words written) -> memWriteEnable and busy drop without waiting for an edge; mem[dst..dst+2] written; mem[dst+3..] unchanged; no done pulse; checksum = 0.

Source files
------------

// File: rtl/mem_copy_engine.sv
// mem_copy_engine: forward word-by-word block copy over a single-port memory
// with a combinational read path and a clocked write. Each word takes one READ
// cycle (capture into the hold register) and one WRITE cycle. A running XOR
// checksum covers every word written by the current or most recent copy.
//
// Handshake: start is a request level sampled only in IDLE; there is no
// ready/ack. A request seen in any other state is dropped, not queued.
// Completion is a single-cycle done pulse in the DONE state. Zero-length
// copies go straight to DONE.
module mem_copy_engine #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 11
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] srcAddr,
    input  logic [ADDR_WIDTH-1:0] dstAddr,
    input  logic [LEN_WIDTH-1:0]  length,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] checksum,
    output logic [ADDR_WIDTH-1:0] memAddress,
    output logic                  memWriteEnable,
    output logic [DATA_WIDTH-1:0] memDataIn,
    input  logic [DATA_WIDTH-1:0] memDataOut,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] src_q, src_d;
    logic [ADDR_WIDTH-1:0] dst_q, dst_d;
    logic [LEN_WIDTH-1:0]  rem_q, rem_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic [DATA_WIDTH-1:0] checksum_q, checksum_d;

    // State and datapath registers; the asynchronous reset clears everything,
    // so every output (all derived from these flops) reaches its reset value
    // without waiting for an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            rem_q      <= '0;
            hold_q     <= '0;
            checksum_q <= '0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            rem_q      <= rem_d;
            hold_q     <= hold_d;
            checksum_q <= checksum_d;
        end
    end

    // Next-state and datapath update logic.
    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        dst_d      = dst_q;
        rem_d      = rem_q;
        hold_d     = hold_q;
        checksum_d = checksum_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    src_d      = srcAddr;
                    dst_d      = dstAddr;
                    rem_d      = length;
                    checksum_d = '0;
                    state_d    = (length != '0) ? ST_READ : ST_DONE;
                end
            end
            ST_READ: begin
                hold_d  = memDataOut;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                // Addresses wrap modulo 2^ADDR_WIDTH; the memory aliases on
                // its low address bits, which is intentionally not flagged.
                checksum_d = checksum_q ^ hold_q;
                src_d      = src_q + ADDR_WIDTH'(1);
                dst_d      = dst_q + ADDR_WIDTH'(1);
                rem_d      = rem_q - LEN_WIDTH'(1);
                state_d    = (rem_q == LEN_WIDTH'(1)) ? ST_DONE : ST_READ;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        busy           = 1'b0;
        done           = 1'b0;
        memAddress     = '0;
        memWriteEnable = 1'b0;
        case (state_q)
            ST_READ: begin
                busy       = 1'b1;
                memAddress = src_q;
            end
            ST_WRITE: begin
                busy           = 1'b1;
                memAddress     = dst_q;
                memWriteEnable = 1'b1;
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign memDataIn = hold_q;
    assign checksum  = checksum_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed bench for mem_copy_engine with a 1024-word behavioural memory.
module tb_mem_copy_engine;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] src_addr;
  logic [31:0] dst_addr;
  logic [10:0] len;
  logic        busy;
  logic        done;
  logic [31:0] checksum;
  logic [31:0] mem_address;
  logic        mem_write_enable;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out;
  logic [1:0]  dbg_state;

  logic [31:0] mem [0:1023];

  int checks;
  int failures;

  mem_copy_engine dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .srcAddr        (src_addr),
    .dstAddr        (dst_addr),
    .length         (len),
    .busy           (busy),
    .done           (done),
    .checksum       (checksum),
    .memAddress     (mem_address),
    .memWriteEnable (mem_write_enable),
    .memDataIn      (mem_data_in),
    .memDataOut     (mem_data_out),
    .dbg_state      (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural memory: combinational read, write on rising edge
  assign mem_data_out = mem[mem_address[9:0]];
  always @(posedge clk) begin
    if (mem_write_enable) mem[mem_address[9:0]] = mem_data_in;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // accept a copy request at the next edge, then watch until done or budget
  task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input logic [10:0] n,
                          output int busy_cyc, output int done_cyc, output int writes);
    busy_cyc = 0;
    done_cyc = 0;
    writes   = 0;
    @(negedge clk);
    src_addr = s;
    dst_addr = d;
    len      = n;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 1; i <= 3000; i++) begin
      @(negedge clk);
      if (busy) busy_cyc++;
      if (mem_write_enable) writes++;
      if (done) begin
        done_cyc = i;
        break;
      end
    end
    if (done_cyc == 0) check("copy_timeout", 32'd0, 32'd1);
  endtask

  int bc, dc, wc;
  bit done_seen;

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    start    = 1'b0;
    src_addr = '0;
    dst_addr = '0;
    len      = '0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_checksum", checksum, 32'd0);
    check("rst_addr", mem_address, 32'd0);
    check("rst_we", {31'd0, mem_write_enable}, 32'd0);
    check("rst_din", mem_data_in, 32'd0);
    reset = 1'b0;

    // 1: basic 4-word copy
    mem[0] = 32'h1111_1111;
    mem[1] = 32'h2222_2222;
    mem[2] = 32'h3333_3333;
    mem[3] = 32'h4444_4444;
    run_copy(32'd0, 32'd16, 11'd4, bc, dc, wc);
    check("t1_busy_cycles", bc, 32'd8);
    check("t1_done_cycle", dc, 32'd9);
    check("t1_writes", wc, 32'd4);
    check("t1_mem16", mem[16], 32'h1111_1111);
    check("t1_mem17", mem[17], 32'h2222_2222);
    check("t1_mem18", mem[18], 32'h3333_3333);
    check("t1_mem19", mem[19], 32'h4444_4444);
    @(negedge clk);
    check("t1_checksum_hold", checksum, 32'h4444_4444);
    check("t1_idle_after", {30'd0, dbg_state}, 32'd0);

    // 2: zero length
    mem[9] = 32'h0909_0909;
    run_copy(32'd5, 32'd9, 11'd0, bc, dc, wc);
    check("t2_done_cycle", dc, 32'd1);
    check("t2_writes", wc, 32'd0);
    check("t2_busy_cycles", bc, 32'd0);
    check("t2_checksum", checksum, 32'd0);
    check("t2_mem9", mem[9], 32'h0909_0909);

    // 3: overlapping forward copy propagates the first word
    mem[0] = 32'hDEAD_BEEF;
    run_copy(32'd0, 32'd1, 11'd4, bc, dc, wc);
    check("t3_mem1", mem[1], 32'hDEAD_BEEF);
    check("t3_mem2", mem[2], 32'hDEAD_BEEF);
    check("t3_mem3", mem[3], 32'hDEAD_BEEF);
    check("t3_mem4", mem[4], 32'hDEAD_BEEF);
    check("t3_checksum", checksum, 32'd0);

    // 4: source wraps past 1023
    mem[1022] = 32'hAAAA_0001;
    mem[1023] = 32'hBBBB_0002;
    mem[0]    = 32'hCCCC_0003;
    mem[1]    = 32'hDDDD_0004;
    run_copy(32'd1022, 32'd100, 11'd4, bc, dc, wc);
    check("t4_mem100", mem[100], 32'hAAAA_0001);
    check("t4_mem101", mem[101], 32'hBBBB_0002);
    check("t4_mem102", mem[102], 32'hCCCC_0003);
    check("t4_mem103", mem[103], 32'hDDDD_0004);
    check("t4_busy_cycles", bc, 32'd8);

    // 5: start while busy is dropped; a later start clears checksum
    mem[400] = 32'h4040_4040;
    @(negedge clk);
    src_addr = 32'd0;
    dst_addr = 32'd200;
    len      = 11'd2;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    bc = 0;
    dc = 0;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      if (busy) bc++;
      if (done) begin
        dc = i;
        break;
      end
      if (i == 1) begin
        src_addr = 32'd300;
        dst_addr = 32'd400;
        len      = 11'd3;
        start    = 1'b1;
      end else if (i == 2) begin
        start = 1'b0;
      end
    end
    check("t5_busy_cycles", bc, 32'd4);
    check("t5_done_cycle", dc, 32'd5);
    check("t5_mem200", mem[200], 32'hCCCC_0003);
    check("t5_mem201", mem[201], 32'hDDDD_0004);
    check("t5_checksum", checksum, 32'h1111_0007);
    repeat (2) @(negedge clk);
    check("t5_no_queue", {31'd0, busy}, 32'd0);
    check("t5_mem400", mem[400], 32'h4040_4040);
    run_copy(32'd2, 32'd210, 11'd1, bc, dc, wc);
    check("t5_second_mem210", mem[210], 32'hDEAD_BEEF);
    check("t5_second_checksum", checksum, 32'hDEAD_BEEF);

    // 6: asynchronous reset in the middle of the 4th word's write cycle
    for (int i = 0; i < 8; i++) begin
      mem[i]       = 32'h6000_0000 + 32'(i);
      mem[500 + i] = 32'h0;
    end
    @(negedge clk);
    src_addr = 32'd0;
    dst_addr = 32'd500;
    len      = 11'd8;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    done_seen = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (done) done_seen = 1'b1;
    end
    check("t6_we_before", {31'd0, mem_write_enable}, 32'd1);
    reset = 1'b1;
    #1;
    check("t6_we_async", {31'd0, mem_write_enable}, 32'd0);
    check("t6_busy_async", {31'd0, busy}, 32'd0);
    check("t6_addr_async", mem_address, 32'd0);
    check("t6_checksum_async", checksum, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) done_seen = 1'b1;
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) done_seen = 1'b1;
    end
    check("t6_no_done", {31'd0, done_seen}, 32'd0);
    check("t6_mem500", mem[500], 32'h6000_0000);
    check("t6_mem501", mem[501], 32'h6000_0001);
    check("t6_mem502", mem[502], 32'h6000_0002);
    check("t6_mem503", mem[503], 32'h0);
    check("t6_mem504", mem[504], 32'h0);
    check("t6_idle", {30'd0, dbg_state}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
